// File: rtl/ov7670_dvp_source.sv
// OV7670 DVP transmit emulator: pclk, vsync, href and an 8-bit byte bus
// driven like the sensor, with pixels from an external stream or a
// built-in test pattern so the capture path can run without a camera.
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   enable          run frames; looked at only on frame boundaries
//   patternSel      0 ext stream, 1 colour bars, 2 row/col, 3 solid white
//   pixelIn/Valid   external RGB565 pixel stream
//   pixelReady      one-clk strobe in the slot that takes a pixel
//   pclk/vsync/href/dvpData  DVP bus (stable at the pclk rising edge)
//   underflow       sticky: an external pixel was missing this frame
//   busy            frame in progress
//   frameCount      completed frames (wraps)
module ov7670_dvp_source #(
  parameter int H_ACTIVE      = 320,
  parameter int V_ACTIVE      = 240,
  parameter int H_BLANK       = 144,
  parameter int V_SYNC_LINES  = 3,
  parameter int V_BACK_LINES  = 17,
  parameter int V_FRONT_LINES = 10,
  parameter int CLK_DIV       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  patternSel,
  input  logic [15:0] pixelIn,
  input  logic        pixelValid,
  output logic        pixelReady,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  dvpData,
  output logic        underflow,
  output logic        busy,
  output logic [15:0] frameCount
);

  localparam int HREF_SLOTS = 2 * H_ACTIVE;
  localparam int LINE_SLOTS = HREF_SLOTS + H_BLANK;
  localparam int BAR_W      = H_ACTIVE / 8;
  localparam int SW         = $clog2(LINE_SLOTS);
  localparam int DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(LINE_SLOTS - 1);
  localparam logic [SW:0]   HREF_END  = (SW + 1)'(HREF_SLOTS);
  localparam logic [15:0]   SYNC_LAST = 16'(V_SYNC_LINES - 1);
  localparam logic [15:0]   BACK_LAST = 16'(V_BACK_LINES - 1);
  localparam logic [15:0]   ACT_LAST  = 16'(V_ACTIVE - 1);
  localparam logic [15:0]   FRNT_LAST = 16'(V_FRONT_LINES - 1);
  localparam logic [15:0]   BAR_LEN   = 16'(BAR_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          pclk_q, pclk_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [15:0]   line_q, line_d;
  logic [1:0]    mode_q, mode_d;
  logic [15:0]   pix_q, pix_d;
  logic [2:0]    bar_q, bar_d;
  logic [15:0]   bcnt_q, bcnt_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    data_q, data_d;
  logic          uf_q, uf_d;
  logic          busy_q, busy_d;
  logic [15:0]   fcnt_q, fcnt_d;

  logic          term;
  logic          tick;
  logic          line_end;
  logic          frame_start;
  logic [SW-1:0] slot_nx;
  logic          in_href;
  logic          fetch;
  logic          rdy;
  logic [7:0]    col;
  logic [2:0]    bar_use;
  logic [15:0]   gen_pix;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  // Divider; a slot tick is the clk in which pclk falls.
  always_comb begin
    term   = (div_q == DIV_LAST);
    tick   = term & pclk_q;
    div_d  = term ? '0 : div_q + 1'b1;
    pclk_d = term ? ~pclk_q : pclk_q;
  end

  // Frame sequencer: slot_q/line_q track the slot currently on the bus.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    line_d      = line_q;
    mode_d      = mode_q;
    busy_d      = busy_q;
    fcnt_d      = fcnt_q;
    frame_start = 1'b0;
    line_end    = (slot_q == LAST_SLOT);
    slot_nx     = line_end ? '0 : slot_q + 1'b1;
    if (tick) begin
      if (state_q != S_IDLE) slot_d = slot_nx;
      unique case (state_q)
        S_IDLE: begin
          if (enable) frame_start = 1'b1;
        end
        S_VSYNC: begin
          if (line_end) begin
            if (line_q == SYNC_LAST) begin
              state_d = S_VBACK;
              line_d  = '0;
            end else begin
              line_d = line_q + 16'd1;
            end
          end
        end
        S_VBACK: begin
          if (line_end) begin
            if (line_q == BACK_LAST) begin
              state_d = S_ACTIVE;
              line_d  = '0;
            end else begin
              line_d = line_q + 16'd1;
            end
          end
        end
        S_ACTIVE: begin
          if (line_end) begin
            if (line_q == ACT_LAST) begin
              state_d = S_VFRONT;
              line_d  = '0;
            end else begin
              line_d = line_q + 16'd1;
            end
          end
        end
        S_VFRONT: begin
          if (line_end) begin
            if (line_q == FRNT_LAST) begin
              fcnt_d = fcnt_q + 16'd1;
              if (enable) begin
                frame_start = 1'b1;
              end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                line_d  = '0;
              end
            end else begin
              line_d = line_q + 16'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (frame_start) begin
        state_d = S_VSYNC;
        slot_d  = '0;
        line_d  = '0;
        mode_d  = patternSel;
        busy_d  = 1'b1;
      end
    end
  end

  // Pixel path: on the tick that enters an even href slot a new pixel
  // is taken and its high byte driven; the odd slot replays its low byte.
  always_comb begin
    in_href = (state_d == S_ACTIVE) && ({1'b0, slot_d} < HREF_END);
    fetch   = tick & in_href & ~slot_d[0];
    col     = 8'(slot_d >> 1);
    rdy     = fetch & (mode_q == 2'd0);

    bar_d   = bar_q;
    bcnt_d  = bcnt_q;
    bar_use = bar_q;
    if (fetch) begin
      if (slot_d == '0) begin
        bar_use = 3'd0;
        bcnt_d  = 16'd1;
      end else if (bcnt_q == BAR_LEN) begin
        bar_use = bar_q + 3'd1;
        bcnt_d  = 16'd1;
      end else begin
        bcnt_d = bcnt_q + 16'd1;
      end
      bar_d = bar_use;
    end

    unique case (mode_q)
      2'd0:    gen_pix = pixelValid ? pixelIn : 16'h0000;
      2'd1:    gen_pix = bar_color(bar_use);
      2'd2:    gen_pix = {line_d[7:0], col};
      default: gen_pix = 16'hFFFF;
    endcase

    uf_d = uf_q;
    if (tick && frame_start) begin
      uf_d = 1'b0;
    end else if (rdy && !pixelValid) begin
      uf_d = 1'b1;
    end

    pix_d   = pix_q;
    vsync_d = vsync_q;
    href_d  = href_q;
    data_d  = data_q;
    if (tick) begin
      vsync_d = (state_d == S_VSYNC);
      href_d  = in_href;
      if (fetch) begin
        pix_d  = gen_pix;
        data_d = gen_pix[15:8];
      end else begin
        data_d = in_href ? pix_q[7:0] : 8'h00;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      pclk_q  <= 1'b0;
      slot_q  <= '0;
      line_q  <= '0;
      mode_q  <= '0;
      pix_q   <= '0;
      bar_q   <= '0;
      bcnt_q  <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= '0;
      uf_q    <= 1'b0;
      busy_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pclk_q  <= pclk_d;
      slot_q  <= slot_d;
      line_q  <= line_d;
      mode_q  <= mode_d;
      pix_q   <= pix_d;
      bar_q   <= bar_d;
      bcnt_q  <= bcnt_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      uf_q    <= uf_d;
      busy_q  <= busy_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign pixelReady = rdy;
  assign pclk       = pclk_q;
  assign vsync      = vsync_q;
  assign href       = href_q;
  assign dvpData    = data_q;
  assign underflow  = uf_q;
  assign busy       = busy_q;
  assign frameCount = fcnt_q;

endmodule

// File: tb/tb_ov7670_dvp_source.sv
// Bench for ov7670_dvp_source: scoreboard of expected DVP bytes,
// popped at each pclk rising edge with href high.
`timescale 1ns/1ps
module tb_ov7670_dvp_source;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  patternSel = 2'd0;
  logic [15:0] pixelIn = 16'hA000;
  logic        pixelValid = 1'b1;
  logic        pixelReady;
  logic        pclk;
  logic        vsync;
  logic        href;
  logic [7:0]  dvpData;
  logic        underflow;
  logic        busy;
  logic [15:0] frameCount;

  logic        enable3 = 1'b0;
  logic        pixelReady3;
  logic        pclk3;
  logic        vsync3;
  logic        href3;
  logic [7:0]  dvpData3;
  logic        underflow3;
  logic        busy3;
  logic [15:0] frameCount3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  bit sb_on = 1'b0;
  bit src_on = 1'b0;
  bit wh_en = 1'b0;
  bit wh_done = 1'b0;
  int src_n = 0;
  int pulse_idx = 0;
  int ready_cnt = 0;
  logic last_rdy = 1'b0;
  logic last_vld = 1'b0;

  ov7670_dvp_source #(
    .H_ACTIVE(8), .V_ACTIVE(2), .H_BLANK(2),
    .V_SYNC_LINES(1), .V_BACK_LINES(1),
    .V_FRONT_LINES(1), .CLK_DIV(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .patternSel(patternSel), .pixelIn(pixelIn),
    .pixelValid(pixelValid), .pixelReady(pixelReady),
    .pclk(pclk), .vsync(vsync), .href(href),
    .dvpData(dvpData), .underflow(underflow),
    .busy(busy), .frameCount(frameCount)
  );

  ov7670_dvp_source #(
    .H_ACTIVE(8), .V_ACTIVE(2), .H_BLANK(2),
    .V_SYNC_LINES(1), .V_BACK_LINES(1),
    .V_FRONT_LINES(1), .CLK_DIV(3)
  ) dut3 (
    .clk(clk), .reset(reset), .enable(enable3),
    .patternSel(patternSel), .pixelIn(pixelIn),
    .pixelValid(pixelValid), .pixelReady(pixelReady3),
    .pclk(pclk3), .vsync(vsync3), .href(href3),
    .dvpData(dvpData3), .underflow(underflow3),
    .busy(busy3), .frameCount(frameCount3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte monitor / scoreboard.
  logic mon_prev = 1'b0;
  logic [7:0] mon_e;
  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      mon_prev = 1'b0;
    end else begin
      if (pclk && !mon_prev) begin
        if (href) begin
          if (sb_on) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL sb_extra got=%h required=none", dvpData);
            end else begin
              mon_e = exp_q.pop_front();
              if (dvpData !== mon_e) begin
                errors++;
                $display("FAIL sb_byte got=%h required=%h", dvpData, mon_e);
              end
            end
          end
        end else begin
          checks++;
          if (dvpData !== 8'h00) begin
            errors++;
            $display("FAIL blank_data got=%h required=00", dvpData);
          end
        end
      end
      mon_prev = pclk;
    end
  end

  // External pixel source: 16'hA000+n, optionally withholding pulse 3.
  always begin
    @(posedge clk);
    #1;
    if (pixelReady) ready_cnt++;
    if (src_on) begin
      if (last_rdy && last_vld) src_n++;
      pixelIn = 16'hA000 + 16'(src_n);
      if (pixelReady) begin
        if (wh_en && !wh_done && pulse_idx == 3) begin
          pixelValid = 1'b0;
          wh_done = 1'b1;
          exp_q.push_back(8'h00);
          exp_q.push_back(8'h00);
        end else begin
          pixelValid = 1'b1;
          exp_q.push_back(pixelIn[15:8]);
          exp_q.push_back(pixelIn[7:0]);
        end
        pulse_idx++;
      end else begin
        pixelValid = 1'b1;
      end
      last_rdy = pixelReady;
      last_vld = pixelValid;
    end else begin
      src_n = 0;
      pulse_idx = 0;
      wh_done = 1'b0;
      last_rdy = 1'b0;
      last_vld = 1'b0;
      pixelValid = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    sb_on = 1'b0;
    src_on = 1'b0;
    wh_en = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pclk, vsync, href, dvpData, pixelReady,
         underflow, busy, frameCount} !== 30'd0) begin
      errors++;
      $display("FAIL reset_state got=%b%b%b %h %b%b%b %h required=all0",
               pclk, vsync, href, dvpData, pixelReady,
               underflow, busy, frameCount);
    end
    #1 reset = 1'b0;
    step();
  endtask

  task automatic test_counter();
    int n;
    int c0;
    int vs;
    logic prev;
    do_reset();
    patternSel = 2'd2;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 8; c++) begin
          exp_q.push_back(8'(r));
          exp_q.push_back(8'(c));
        end
    sb_on = 1'b1;
    enable = 1'b1;
    n = 0;
    while (vsync !== 1'b1 && n < 100) begin step(); n++; end
    c0 = cyc;
    checks++;
    if (vsync !== 1'b1) begin
      errors++;
      $display("FAIL t1_vsync_start got=%b required=1", vsync);
    end
    vs = 0;
    prev = pclk;
    n = 0;
    while (vsync === 1'b1 && n < 200) begin
      step();
      n++;
      if (pclk && !prev && vsync) vs++;
      prev = pclk;
    end
    checks++;
    if (vs != 18) begin
      errors++;
      $display("FAIL t1_vsync_len got=%0d required=18", vs);
    end
    n = 0;
    while (frameCount !== 16'd1 && n < 400) begin step(); n++; end
    checks++;
    if (cyc - c0 != 180) begin
      errors++;
      $display("FAIL t1_frame_time got=%0d required=180", cyc - c0);
    end
    checks++;
    if (vsync !== 1'b1) begin
      errors++;
      $display("FAIL t1_next_vsync got=%b required=1", vsync);
    end
    enable = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin step(); n++; end
    checks++;
    if (frameCount !== 16'd2) begin
      errors++;
      $display("FAIL t1_count got=%0d required=2", frameCount);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL t1_sb_left got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_bars();
    int n;
    int r0;
    logic [15:0] bars [8];
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
             16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    do_reset();
    patternSel = 2'd1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 8; c++) begin
        exp_q.push_back(bars[c][15:8]);
        exp_q.push_back(bars[c][7:0]);
      end
    r0 = ready_cnt;
    sb_on = 1'b1;
    enable = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin step(); n++; end
    enable = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin step(); n++; end
    checks++;
    if (exp_q.size() != 0 || frameCount !== 16'd1) begin
      errors++;
      $display("FAIL t2_frame left=%0d cnt=%0d required=0,1",
               exp_q.size(), frameCount);
    end
    checks++;
    if (ready_cnt - r0 != 0) begin
      errors++;
      $display("FAIL t2_ready got=%0d required=0", ready_cnt - r0);
    end
  endtask

  task automatic test_stream();
    int n;
    int r0;
    do_reset();
    patternSel = 2'd0;
    src_on = 1'b1;
    r0 = ready_cnt;
    sb_on = 1'b1;
    enable = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin step(); n++; end
    enable = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin step(); n++; end
    checks++;
    if (ready_cnt - r0 != 16) begin
      errors++;
      $display("FAIL t3_ready got=%0d required=16", ready_cnt - r0);
    end
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL t3_underflow got=%b required=0", underflow);
    end
    checks++;
    if (exp_q.size() != 0 || src_n != 16) begin
      errors++;
      $display("FAIL t3_consumed left=%0d n=%0d required=0,16",
               exp_q.size(), src_n);
    end
    src_on = 1'b0;
  endtask

  task automatic test_underflow();
    int n;
    logic prev_uf;
    do_reset();
    patternSel = 2'd0;
    src_on = 1'b1;
    wh_en = 1'b1;
    sb_on = 1'b1;
    enable = 1'b1;
    n = 0;
    while (pulse_idx <= 3 && n < 200) begin step(); n++; end
    repeat (2) step();
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL t4_uf_set got=%b required=1", underflow);
    end
    prev_uf = underflow;
    n = 0;
    while (frameCount !== 16'd1 && n < 400) begin
      prev_uf = underflow;
      step();
      n++;
    end
    checks++;
    if (prev_uf !== 1'b1 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL t4_uf_sticky got=%b,%b required=1,0",
               prev_uf, underflow);
    end
    enable = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin step(); n++; end
    checks++;
    if (exp_q.size() != 0 || frameCount !== 16'd2) begin
      errors++;
      $display("FAIL t4_frames left=%0d cnt=%0d required=0,2",
               exp_q.size(), frameCount);
    end
    src_on = 1'b0;
    wh_en = 1'b0;
  endtask

  task automatic test_enable_drop();
    int n;
    bit vs_seen;
    do_reset();
    patternSel = 2'd3;
    for (int i = 0; i < 32; i++) exp_q.push_back(8'hFF);
    sb_on = 1'b1;
    enable = 1'b1;
    n = 0;
    while (href !== 1'b1 && n < 200) begin step(); n++; end
    enable = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin step(); n++; end
    checks++;
    if (frameCount !== 16'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL t5_complete cnt=%0d left=%0d required=1,0",
               frameCount, exp_q.size());
    end
    vs_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (vsync !== 1'b0 || busy !== 1'b0) vs_seen = 1'b1;
    end
    checks++;
    if (vs_seen) begin
      errors++;
      $display("FAIL t5_idle got=active required=idle");
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int c1;
    logic prev;
    bit act;
    do_reset();
    patternSel = 2'd2;
    enable = 1'b1;
    n = 0;
    while (href !== 1'b1 && n < 200) begin step(); n++; end
    repeat (3) step();
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({pclk, vsync, href, dvpData, pixelReady,
         underflow, busy, frameCount} !== 30'd0) begin
      errors++;
      $display("FAIL t6_async got=%b%b%b %h %b%b%b required=all0",
               pclk, vsync, href, dvpData, pixelReady, underflow, busy);
    end
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    act = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (vsync !== 1'b0 || busy !== 1'b0 || href !== 1'b0) act = 1'b1;
    end
    checks++;
    if (act) begin
      errors++;
      $display("FAIL t6_stay_idle got=active required=idle");
    end
    enable = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 10) begin step(); n++; end
    checks++;
    if (busy !== 1'b1 || vsync !== 1'b1) begin
      errors++;
      $display("FAIL t6_restart busy=%b vsync=%b required=1,1", busy, vsync);
    end
    enable = 1'b0;
    prev = pclk3;
    n = 0;
    while (!(pclk3 && !prev) && n < 20) begin prev = pclk3; step(); n++; end
    c1 = cyc;
    prev = pclk3;
    step();
    n = 0;
    while (!(pclk3 && !prev) && n < 20) begin prev = pclk3; step(); n++; end
    checks++;
    if (cyc - c1 != 6) begin
      errors++;
      $display("FAIL t6_div3_period got=%0d required=6", cyc - c1);
    end
    checks++;
    if ({vsync3, href3, dvpData3, pixelReady3,
         underflow3, busy3, frameCount3} !== 29'd0) begin
      errors++;
      $display("FAIL t6_div3_idle got=%b%b %h %b%b%b %h required=all0",
               vsync3, href3, dvpData3, pixelReady3,
               underflow3, busy3, frameCount3);
    end
  endtask

  initial begin
    test_reset();
    test_counter();
    test_bars();
    test_stream();
    test_underflow();
    test_enable_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
